conv_feeder: RTL
================

Name: conv_feeder

Overview:
- Source side of the ConvTop input interface.
- On a start pulse it reads KernelSize weight words, then row*col pixel words, from a single-port synchronous-read memory holding all Channels lanes per word.
- It streams them on weight_in/weight_valid and data_in/data_valid, in exactly the beat order and spacing ConvTop consumes.
- It replaces testbench-driven stimulus in the integrated datapath and reports busy/done to the controller.

Parameters:
DataWidth, 64, width of one channel lane (signed two's complement)
Channels, 4, lanes per memory word / per beat
KernelSize, 9, weight beats per load (3x3 kernel, row-major)
AddrWidth, 16, memory address width
GapCycles, 4, idle cycles between last weight beat and first data beat (>=1)
MaxSize, 256, largest legal row/col value

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, synchronous, active-low
start  in  1  single-cycle request, sampled only in IDLE
row_in  in  9  image rows for this job
col_in  in  9  image columns for this job
weight_base  in  AddrWidth  address of weight beat 0
data_base  in  AddrWidth  address of pixel (1,1)
mem_rd  out  1  memory read strobe
mem_addr  out  AddrWidth  memory read address
mem_rdata  in  Channels*DataWidth  read data, valid exactly 1 cycle after mem_rd
row_out  out  9  latched row_in, drives ConvTop row_in
col_out  out  9  latched col_in, drives ConvTop col_in
weight_in  out  Channels*DataWidth  weight beat, lane k at [k*DataWidth +: DataWidth]
weight_valid  out  1  weight beat qualifier
data_in  out  Channels*DataWidth  pixel beat, same lane packing
data_valid  out  1  pixel beat qualifier
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse, job complete
err  out  1  one-cycle pulse, start rejected (only with feature enabled)

Behaviour:
- Reset (Rst==0 at an edge): state IDLE; all outputs 0, including row_out/col_out and mem_addr.
  - Reset mid-job aborts the job immediately: no done, and no further beats at or after that edge.
- States: IDLE -> WEIGHT -> GAP -> DATA -> FIN -> IDLE.
- IDLE, start=1 at edge S:
  - Latch row_in, col_in, weight_base and data_base; busy=1; go to WEIGHT.
  - start in any other state is ignored.
- WEIGHT:
  - mem_rd=1 for KernelSize consecutive cycles, addresses weight_base+0..KernelSize-1.
  - Read data is registered into weight_in, so weight beat n appears at edge S+2+n, n=0..KernelSize-1.
  - weight_valid is contiguous for KernelSize cycles.
- GAP:
  - weight_valid and data_valid are both 0 for exactly GapCycles cycles.
  - Data reads may be prefetched into the pipeline, but no beat is emitted.
- DATA:
  - Pixels are read at data_base + linear index, index 0..row*col-1, row-major (column fastest).
  - First data beat at edge S+2+KernelSize+GapCycles.
  - data_valid is contiguous for row*col cycles, with no bubbles.
- FIN: done=1 for one cycle at the edge after the last data beat; busy=0 on the same edge; return to IDLE.
- When a qualifier is 0, its bus is driven to all-zero (ConvTop samples lanes only when valid, but zero buses keep waveform diffs clean).
- Address arithmetic is modulo 2^AddrWidth; base+offset wraps silently.
- Pixel counter width is 17 bits, holding up to 256*256.
- Data is passed through unmodified; no sign handling inside the block.
- row_in=0 or col_in=0 with the feature disabled: DATA phase is skipped and done follows the GAP phase.
- row_out/col_out hold their latched value after done, until the next accepted start.

Optional Feature:
CONV_FEEDER_SIZE_CHECK_EN
- Defined:
  - At the start edge, if row_in or col_in is 0 or exceeds MaxSize, the job is rejected.
  - On rejection: err=1 for one cycle at the next edge; state stays IDLE; busy, done, mem_rd and the qualifiers stay 0; latched registers are not updated.
- Undefined: err is tied to 0 and every start is accepted.

Test Plan:
- Basic 8x8 job:
  - Setup: memory word at address a = {4{a}}; weight_base=0x100, data_base=0x200, GapCycles=4; start at edge S.
  - Required: weight_valid at edges S+2..S+10 with lane0 = 0x100..0x108.
  - Required: data_valid at edges S+15..S+78 with lane0 = 0x200..0x23F.
  - Required: done at S+79.
- Back-to-back: a second start pulses during busy -> ignored; a start one cycle after done -> new job whose first weight beat is 2 edges later.
- Wrap-around: data_base=0xFFFE, 2x2 job -> data lane0 sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-DATA: Rst=0 at the 20th data beat -> next edge has all outputs 0 and no done; a fresh start afterwards completes normally.
- Signed pass-through: memory lane2 = -7 (64'hFFFF_FFFF_FFFF_FFF9) -> identical bits on weight_in[128 +: 64].
- Feature on, row_in=0 or col_in=300 -> err pulse 1 cycle, busy stays 0, no mem_rd. Feature off, row_in=0 -> 9 weight beats, gap, done, zero data beats.

Source files
------------

// File: rtl/conv_feeder.sv
// Memory-to-ConvTop stimulus feeder: weights, a fixed gap, then row*col pixels.
// Optional start-time size check under CONV_FEEDER_SIZE_CHECK_EN.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_WEIGHT | issuing KernelSize weight reads
// S_GAP    | GapCycles issue slots with no reads
// S_DATA   | issuing row*col pixel reads
// S_FIN    | draining the read pipeline, then done
module conv_feeder #(
  parameter int DataWidth  = 64,
  parameter int Channels   = 4,
  parameter int KernelSize = 9,
  parameter int AddrWidth  = 16,
  parameter int GapCycles  = 4,
  parameter int MaxSize    = 256
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            start,
  input  logic [8:0]                      row_in,
  input  logic [8:0]                      col_in,
  input  logic [AddrWidth-1:0]            weight_base,
  input  logic [AddrWidth-1:0]            data_base,
  output logic                            mem_rd,
  output logic [AddrWidth-1:0]            mem_addr,
  input  logic [Channels*DataWidth-1:0]   mem_rdata,
  output logic [8:0]                      row_out,
  output logic [8:0]                      col_out,
  output logic [Channels*DataWidth-1:0]   weight_in,
  output logic                            weight_valid,
  output logic [Channels*DataWidth-1:0]   data_in,
  output logic                            data_valid,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int BusW = Channels * DataWidth;
  localparam int CntW = $clog2(MaxSize * MaxSize + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WEIGHT,
    S_GAP,
    S_DATA,
    S_FIN
  } state_t;

  state_t               r_state;
  logic [CntW-1:0]      r_cnt;
  logic [8:0]           r_row;
  logic [8:0]           r_col;
  logic [AddrWidth-1:0] r_data_base;
  logic                 r_mem_rd;
  logic [AddrWidth-1:0] r_mem_addr;
  logic                 r_pipe_w;
  logic                 r_pipe_d;
  logic [BusW-1:0]      r_weight_in;
  logic                 r_weight_valid;
  logic [BusW-1:0]      r_data_in;
  logic                 r_data_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic [17:0]          w_npix;
  logic [17:0]          w_last_pix;
  logic                 w_size_ok;

  assign w_npix     = {9'd0, r_row} * {9'd0, r_col};
  assign w_last_pix = w_npix - 18'd1;

`ifdef CONV_FEEDER_SIZE_CHECK_EN
  assign w_size_ok = (row_in != 9'd0) && (col_in != 9'd0) &&
                     (int'(row_in) <= MaxSize) && (int'(col_in) <= MaxSize);
`else
  assign w_size_ok = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_row          <= '0;
      r_col          <= '0;
      r_data_base    <= '0;
      r_mem_rd       <= 1'b0;
      r_mem_addr     <= '0;
      r_pipe_w       <= 1'b0;
      r_pipe_d       <= 1'b0;
      r_weight_in    <= '0;
      r_weight_valid <= 1'b0;
      r_data_in      <= '0;
      r_data_valid   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      // A read issued in WEIGHT/DATA returns next cycle and is registered the cycle after.
      r_pipe_w       <= r_mem_rd && (r_state == S_WEIGHT);
      r_pipe_d       <= r_mem_rd && (r_state == S_DATA);
      r_weight_valid <= r_pipe_w;
      r_weight_in    <= r_pipe_w ? mem_rdata : '0;
      r_data_valid   <= r_pipe_d;
      r_data_in      <= r_pipe_d ? mem_rdata : '0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_size_ok) begin
              r_row       <= row_in;
              r_col       <= col_in;
              r_data_base <= data_base;
              r_busy      <= 1'b1;
              r_mem_rd    <= 1'b1;
              r_mem_addr  <= weight_base;
              r_cnt       <= CntW'(KernelSize - 1);
              r_state     <= S_WEIGHT;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_WEIGHT: begin
          if (r_cnt == '0) begin
            r_mem_rd <= 1'b0;
            r_cnt    <= CntW'(GapCycles - 1);
            r_state  <= S_GAP;
          end else begin
            r_mem_addr <= r_mem_addr + AddrWidth'(1);
            r_cnt      <= r_cnt - CntW'(1);
          end
        end

        S_GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CntW'(1);
          end else if (w_npix == 18'd0) begin
            r_cnt   <= CntW'(1);
            r_state <= S_FIN;
          end else begin
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_data_base;
            r_cnt      <= w_last_pix[CntW-1:0];
            r_state    <= S_DATA;
          end
        end

        S_DATA: begin
          if (r_cnt == '0) begin
            r_mem_rd <= 1'b0;
            r_cnt    <= CntW'(1);
            r_state  <= S_FIN;
          end else begin
            r_mem_addr <= r_mem_addr + AddrWidth'(1);
            r_cnt      <= r_cnt - CntW'(1);
          end
        end

        S_FIN: begin
          // Two drain cycles let the final pixel leave the read pipeline before done.
          if (r_cnt == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd       = r_mem_rd;
  assign mem_addr     = r_mem_addr;
  assign row_out      = r_row;
  assign col_out      = r_col;
  assign weight_in    = r_weight_in;
  assign weight_valid = r_weight_valid;
  assign data_in      = r_data_in;
  assign data_valid   = r_data_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule
